// File: rtl/mi_arb2.sv
// rtl/mi_arb2.sv - two-requester arbiter onto one memory interface
// Single outstanding transaction; port 0 preferred, port 1 protected from starvation.
module mi_arb2 #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] p0_addr,
  input  logic [6:0]  p0_len,
  input  logic        p0_rw,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic [31:0] p0_wdata,
  output logic        p0_wack,
  output logic        p0_wlast,
  output logic [31:0] p0_rdata,
  output logic        p0_rstb,
  output logic        p0_rlast,

  input  logic [31:0] p1_addr,
  input  logic [6:0]  p1_len,
  input  logic        p1_rw,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic [31:0] p1_wdata,
  output logic        p1_wack,
  output logic        p1_wlast,
  output logic [31:0] p1_rdata,
  output logic        p1_rstb,
  output logic        p1_rlast,

  output logic [31:0] mi_addr,
  output logic [6:0]  mi_len,
  output logic        mi_rw,
  output logic        mi_valid,
  input  logic        mi_ready,
  output logic [31:0] mi_wdata,
  input  logic        mi_wack,
  input  logic        mi_wlast,
  input  logic [31:0] mi_rdata,
  input  logic        mi_rstb,
  input  logic        mi_rlast
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, CMD, RD, WR} state_t;

  state_t     state;
  state_t     state_nxt;
  logic       gnt;
  logic       gnt_nxt;
  logic [3:0] starve_cnt;
  logic [3:0] starve_nxt;
  logic       pick_p1;
  logic       in_cmd;
  logic       in_rd;
  logic       in_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    starve_nxt = starve_cnt;
    pick_p1    = p1_valid & (~p0_valid | (starve_cnt == STARVE_LIM));
    case (state)
      IDLE: begin
        if (p0_valid | p1_valid) begin
          state_nxt = CMD;
          gnt_nxt   = pick_p1;
          // Count only port-0 wins that actually made port 1 wait.
          if (pick_p1)
            starve_nxt = 4'd0;
          else if (p1_valid && starve_cnt != 4'hf)
            starve_nxt = starve_cnt + 4'd1;
        end
      end
      CMD: begin
        if (mi_ready)
          state_nxt = mi_rw ? RD : WR;
      end
      RD: begin
        if (mi_rstb & mi_rlast)
          state_nxt = IDLE;
      end
      WR: begin
        if (mi_wack & mi_wlast)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_cmd = (state == CMD);
  assign in_rd  = (state == RD);
  assign in_wr  = (state == WR);

  assign mi_valid = in_cmd;
  assign mi_addr  = gnt ? p1_addr : p0_addr;
  assign mi_len   = gnt ? p1_len  : p0_len;
  assign mi_rw    = gnt ? p1_rw   : p0_rw;

  assign p0_ready = in_cmd & ~gnt & mi_ready;
  assign p1_ready = in_cmd &  gnt & mi_ready;

  // Strobes outside the owning state are dropped, which also covers spurious beats.
  assign p0_rdata = mi_rdata;
  assign p1_rdata = mi_rdata;
  assign p0_rstb  = in_rd & ~gnt & mi_rstb;
  assign p1_rstb  = in_rd &  gnt & mi_rstb;
  assign p0_rlast = in_rd & ~gnt & mi_rlast;
  assign p1_rlast = in_rd &  gnt & mi_rlast;

  assign mi_wdata = (in_wr & gnt) ? p1_wdata : p0_wdata;
  assign p0_wack  = in_wr & ~gnt & mi_wack;
  assign p1_wack  = in_wr &  gnt & mi_wack;
  assign p0_wlast = in_wr & ~gnt & mi_wlast;
  assign p1_wlast = in_wr &  gnt & mi_wlast;

endmodule

// File: doc/mi_arb2.md
MI_ARB2 -- requirements
Module: mi_arb2

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, range 1..15: max consecutive port-0 grants while port 1 waits.
REQ-002 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, reset); one clock, reset asynchronous and active-high.
REQ-003 SHALL have, for N in {0,1}, requester command inputs pN_addr (32), pN_len (7, beats-1), pN_rw (1, 1=read) and pN_valid (1), plus output pN_ready (1).
REQ-004 SHALL have, per N, write-data ports pN_wdata (in, 32) and pN_wack, pN_wlast (out, 1 each).
REQ-005 SHALL have, per N, read-data ports pN_rdata (out, 32) and pN_rstb, pN_rlast (out, 1 each).
REQ-006 SHALL have memory command outputs mi_addr (32), mi_len (7), mi_rw (1) and mi_valid (1), plus input mi_ready (1).
REQ-007 SHALL have memory write-data ports mi_wdata (out, 32) and mi_wack, mi_wlast (in, 1 each).
REQ-008 SHALL have memory read-data inputs mi_rdata (32), mi_rstb (1) and mi_rlast (1).

Function
REQ-009 SHALL share one memory interface between two requesters with at most one transaction outstanding.
REQ-010 SHALL implement FSM states IDLE, CMD, RD and WR, plus a grant register gnt (0/1).
REQ-011 In IDLE with any pN_valid, SHALL latch gnt and go to CMD next cycle; mi_valid rises 1 cycle after pN_valid is first seen in IDLE.
REQ-012 SHALL pick port 1 if p1_valid and (~p0_valid or starve_cnt==STARVE_MAX), else port 0.
REQ-013 starve_cnt (4 bit, saturating) SHALL increment on each port-0 grant with p1_valid high, clear on each port-1 grant and otherwise hold.
REQ-014 In CMD, mi_valid SHALL be 1 and mi_addr/mi_len/mi_rw SHALL mirror the granted port's fields combinationally.
REQ-015 In CMD, p[gnt]_ready SHALL equal mi_ready, and the other port's ready SHALL be 0.
REQ-016 Outside CMD, mi_valid and both pN_ready SHALL be 0.
REQ-017 On mi_valid&mi_ready, SHALL go to RD if mi_rw=1, else to WR.
REQ-018 mi_rdata SHALL be broadcast combinationally to both pN_rdata.
REQ-019 In RD, p[gnt]_rstb=mi_rstb and p[gnt]_rlast=mi_rlast; the other port's strobes SHALL be 0.
REQ-020 In RD, mi_rstb&mi_rlast SHALL return the FSM to IDLE.
REQ-021 In WR, mi_wdata=p[gnt]_wdata, p[gnt]_wack=mi_wack and p[gnt]_wlast=mi_wlast; the other port's strobes SHALL be 0.
REQ-022 In WR, mi_wack&mi_wlast SHALL return the FSM to IDLE.
REQ-023 Outside WR, mi_wdata SHALL be p0_wdata (don't-care to memory).
REQ-024 mi_rstb/mi_wack arriving in IDLE or CMD SHALL be dropped, with no pN strobe and no state change.
REQ-025 Min turnaround: last data strobe in cycle T, IDLE in T+1, next mi_valid in T+2.
REQ-026 Requesters hold fields stable while pN_valid=1; valid dropping in CMD is a protocol violation, and the block stays in CMD.
REQ-027 mi_len SHALL pass through unmodified, with no beat counting inside the block.

Reset
REQ-028 rst SHALL force, asynchronously and at any time including mid-burst, state=IDLE, gnt=0 and starve_cnt=0.
REQ-029 During and after rst, SHALL drive mi_valid=0, pN_ready=0, pN_rstb=0, pN_rlast=0, pN_wack=0 and pN_wlast=0.
REQ-030 After rst deasserts, the first rising clk edge SHALL evaluate arbitration normally.

Verification
REQ-031 p0 read: addr=0x100, len=3 -> mi_valid 1 cycle later with mi_addr=0x100, mi_rw=1; 4 mi_rstb pulses appear on p0_rstb; p0_rlast on 4th; p1_rstb always 0; IDLE after.
REQ-032 p0_valid and p1_valid held high, all reads len=0, STARVE_MAX=4 -> grant order p0,p0,p0,p0,p1,p0,p0,p0,p0,p1.
REQ-033 p1 write: len=1 -> mi_rw=0; mi_wdata tracks p1_wdata; 2 p1_wack; p1_wlast on 2nd; p0_wack=0.
REQ-034 rst pulse after 2 of 8 read strobes -> mi_valid=0 and FSM=IDLE immediately; remaining 6 strobes not forwarded; new p1 request then served normally.
REQ-035 mi_ready held low 10 cycles in CMD -> mi_valid=1 and fields stable throughout; pN_ready=0 until the accept cycle; exactly one accept.
REQ-036 Spurious mi_rstb in IDLE -> no pN_rstb; FSM stays IDLE.
